dp_ram_pipe: RTL and testbench
==============================

DP_RAM_PIPE -- requirements
Module: dp_ram_pipe

Interface
REQ-001 SHALL have parameter NUMBER_OF_LINES, default 8192: memory depth in words.
REQ-002 SHALL have parameter DATA_WIDTH, default 128: word width in bits, a multiple of 8.
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal range 1..4: cycles from r_en to mem_valid.
REQ-004 SHALL have parameter BYPASS_EN, default 1: 1 = write-first on address collision, 0 = read-first.
REQ-005 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-007 SHALL have port w_en  input  1: write request.
REQ-008 SHALL have port w_be  input  DATA_WIDTH/8: byte enables; bit i qualifies wr_data[8i+7:8i].
REQ-009 SHALL have port addr_w  input  $clog2(NUMBER_OF_LINES): write address.
REQ-010 SHALL have port wr_data  input  DATA_WIDTH: write data.
REQ-011 SHALL have port r_en  input  1: read request.
REQ-012 SHALL have port addr_r  input  $clog2(NUMBER_OF_LINES): read address.
REQ-013 SHALL have port rd_data  output  DATA_WIDTH: read data, qualified by mem_valid.
REQ-014 SHALL have port mem_valid  output  1: rd_data is valid this cycle.
REQ-015 SHALL have port init_done  output  1: high once the post-reset clear sweep is complete.

Function
REQ-016 SHALL implement a two-state FSM: INIT (entered at reset) and READY.
REQ-017 In INIT, SHALL write all-zero words to addresses 0..NUMBER_OF_LINES-1, one per cycle, using an internal address counter.
REQ-018 SHALL go from INIT to READY on the cycle after address NUMBER_OF_LINES-1 is written; init_done SHALL rise in that cycle and stay high until the next reset.
REQ-019 In INIT, w_en and r_en SHALL be ignored: no user write takes place and no read is issued.
REQ-020 In READY with w_en=1, SHALL update only the bytes of mem[addr_w] whose w_be bit is 1; w_be=0 SHALL leave the word unchanged.
REQ-021 A read accepted at cycle T SHALL assert mem_valid at T+READ_LATENCY, together with its data; back-to-back reads SHALL be fully pipelined at one per cycle.
REQ-022 When mem_valid is 0, rd_data SHALL be all zeros.
REQ-023 On a same-cycle read and write to the same address with BYPASS_EN=1, read data SHALL be the old word merged with the wr_data bytes selected by w_be.
REQ-024 On that same collision with BYPASS_EN=0, read data SHALL be the old word.
REQ-025 A write issued after a read is accepted SHALL NOT change that read's returned data.
REQ-026 Reads and writes to different addresses in the same cycle SHALL be independent.
REQ-027 Addresses SHALL be used unsigned without wrap logic; behaviour for addresses >= NUMBER_OF_LINES is undefined.

Reset
REQ-028 On rst_n low, SHALL asynchronously clear mem_valid, rd_data, init_done, all pipeline valid bits and the sweep counter, and enter INIT.
REQ-029 Memory contents SHALL NOT be reset directly; they are cleared only by the INIT sweep.
REQ-030 Reset asserted mid-sweep or mid-pipeline SHALL discard in-flight reads, and the sweep SHALL restart from address 0 after reset is released.

Structure
REQ-031 Package dp_ram_pkg SHALL hold the FSM state typedef and the READ_LATENCY bounds constants.
REQ-032 The storage array plus first read register SHALL be the sub-module dp_ram_array; the latency pipeline, bypass merge, FSM and sweep logic SHALL live in dp_ram_pipe.
REQ-033 A READ_LATENCY outside 1..4 SHALL trigger an elaboration-time error.

Verification
REQ-034 Reset, NUMBER_OF_LINES=16 -> init_done rises exactly 16 cycles after rst_n release; reads of all addresses return 0.
REQ-035 Write 0xAA..AA to addr 5 with all w_be bits set, then write 0x55..55 with w_be=...0001 -> read of addr 5 returns 0xAA..A55.
REQ-036 READ_LATENCY=3, reads on 4 consecutive cycles to addrs 1-4 -> mem_valid high for 4 cycles starting at T+3, data in issue order.
REQ-037 Collision at addr 7 (old value 0x11.., new value 0x22.., all w_be bits set) -> read returns 0x22.. with BYPASS_EN=1 and 0x11.. with BYPASS_EN=0.
REQ-038 rst_n pulsed mid-sweep and with reads in flight -> mem_valid=0 immediately, no stale data returned, sweep restarts at address 0.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: shared FSM state type and read-latency bounds for the pipelined dual-port RAM.
package dp_ram_pkg;
    typedef enum logic {INIT, READY} state_t;
    localparam int RL_MIN = 1;
    localparam int RL_MAX = 4;
endpackage

// File: rtl/dp_ram_pipe_if.sv
// dp_ram_pipe_if: write/read request bus and read-response signals of the pipelined RAM.
interface dp_ram_pipe_if #(
    parameter int NUMBER_OF_LINES = 8192,
    parameter int DATA_WIDTH      = 128
);
    logic                               w_en;
    logic [DATA_WIDTH/8-1:0]            w_be;
    logic [$clog2(NUMBER_OF_LINES)-1:0] addr_w;
    logic [DATA_WIDTH-1:0]              wr_data;
    logic                               r_en;
    logic [$clog2(NUMBER_OF_LINES)-1:0] addr_r;
    logic [DATA_WIDTH-1:0]              rd_data;
    logic                               mem_valid;
    logic                               init_done;
    modport master (output w_en, w_be, addr_w, wr_data, r_en, addr_r, input rd_data, mem_valid, init_done);
    modport slave  (input w_en, w_be, addr_w, wr_data, r_en, addr_r, output rd_data, mem_valid, init_done);
endinterface

// File: rtl/dp_ram_array.sv
// dp_ram_array: byte-writable storage with one registered, read-first read port.
module dp_ram_array #(
    parameter int NUMBER_OF_LINES = 8192,
    parameter int DATA_WIDTH      = 128
) (
    input  logic                               clk,
    input  logic                               we,
    input  logic [DATA_WIDTH/8-1:0]            be,
    input  logic [$clog2(NUMBER_OF_LINES)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic                               re,
    input  logic [$clog2(NUMBER_OF_LINES)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]              rdata
);
    logic [DATA_WIDTH-1:0] mem [NUMBER_OF_LINES];
    // Contents are never reset; the owner clears them with a sweep.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        if (we)
            for (int i = 0; i < DATA_WIDTH/8; i++)
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: rtl/dp_ram_pipe.sv
// dp_ram_pipe: dual-port RAM with post-reset clear sweep, collision bypass
// and a configurable read-latency pipeline.
module dp_ram_pipe
    import dp_ram_pkg::*;
#(
    parameter int NUMBER_OF_LINES = 8192,
    parameter int DATA_WIDTH      = 128,
    parameter int READ_LATENCY    = 1,
    parameter int BYPASS_EN       = 1
) (
    input logic clk,
    input logic rst_n,
    dp_ram_pipe_if.slave bus
);
    localparam int AW = $clog2(NUMBER_OF_LINES);
    localparam int BW = DATA_WIDTH / 8;
    if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_latency
        $error("dp_ram_pipe: READ_LATENCY must be within 1..4");
    end
    state_t                  state, state_nx;
    logic [AW-1:0]           cnt, cnt_nx;
    logic                    rdy, issue;
    logic [BW-1:0]           byp_be;
    logic [DATA_WIDTH-1:0]   byp_data, arr_q, merged, out_data;
    logic [READ_LATENCY-1:0] vld;
    assign rdy   = state == READY;
    assign issue = rdy & bus.r_en;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    always_comb begin
        state_nx = (state == INIT && cnt == AW'(NUMBER_OF_LINES - 1)) ? READY : state;
        cnt_nx   = (state == INIT) ? cnt + 1'b1 : cnt;
    end
    // During INIT the write port is owned by the sweep; user traffic is dropped.
    dp_ram_array #(.NUMBER_OF_LINES(NUMBER_OF_LINES), .DATA_WIDTH(DATA_WIDTH)) u_array (
        .clk  (clk),
        .we   (!rdy || bus.w_en),
        .be   (rdy ? bus.w_be : '1),
        .waddr(rdy ? bus.addr_w : cnt),
        .wdata(rdy ? bus.wr_data : '0),
        .re   (issue),
        .raddr(bus.addr_r),
        .rdata(arr_q)
    );
    // The array returns the pre-write word; the colliding write's bytes are merged afterwards.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            byp_be   <= '0;
            byp_data <= '0;
            vld      <= '0;
        end else begin
            byp_be   <= (BYPASS_EN != 0 && issue && bus.w_en && bus.addr_w == bus.addr_r) ? bus.w_be : '0;
            byp_data <= bus.wr_data;
            vld[0]   <= issue;
            for (int i = 1; i < READ_LATENCY; i++) vld[i] <= vld[i-1];
        end
    always_comb begin
        merged = arr_q;
        for (int i = 0; i < BW; i++)
            merged[8*i +: 8] = byp_be[i] ? byp_data[8*i +: 8] : arr_q[8*i +: 8];
    end
    if (READ_LATENCY == 1) begin : g_direct
        assign out_data = merged;
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0] pdat [READ_LATENCY-1];
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                for (int i = 0; i < READ_LATENCY - 1; i++) pdat[i] <= '0;
            end else begin
                pdat[0] <= merged;
                for (int i = 1; i < READ_LATENCY - 1; i++) pdat[i] <= pdat[i-1];
            end
        assign out_data = pdat[READ_LATENCY-2];
    end
    assign bus.mem_valid = vld[READ_LATENCY-1];
    assign bus.rd_data   = vld[READ_LATENCY-1] ? out_data : '0;
    assign bus.init_done = rdy;
endmodule

// File: tb/tb_dp_ram_pipe.sv
// tb_dp_ram_pipe: two instances (latency 3 write-first, latency 1 read-first) share directed
// stimulus; expected responses are queued at issue and popped by a monitor on mem_valid.
module tb_dp_ram_pipe;
    localparam int N  = 16;
    localparam int DW = 32;
    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;
    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    exp_t q[2][$];
    dp_ram_pipe_if #(.NUMBER_OF_LINES(N), .DATA_WIDTH(DW)) ifa ();
    dp_ram_pipe_if #(.NUMBER_OF_LINES(N), .DATA_WIDTH(DW)) ifb ();
    dp_ram_pipe #(.NUMBER_OF_LINES(N), .DATA_WIDTH(DW), .READ_LATENCY(3), .BYPASS_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    dp_ram_pipe #(.NUMBER_OF_LINES(N), .DATA_WIDTH(DW), .READ_LATENCY(1), .BYPASS_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    task automatic chk(string n, logic [DW-1:0] act, logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, req);
        end
    endtask
    task automatic mon(int k, logic v, logic [DW-1:0] d);
        exp_t e;
        if (!v) chk($sformatf("idle_zero%0d", k), d, '0);
        else if (q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid%0d: got data %h expected no response", k, d);
        end else begin
            e = q[k].pop_front();
            chk($sformatf("rd_data%0d", k), d, e.d);
            chk($sformatf("latency%0d", k), cyc, e.due);
        end
    endtask
    always @(negedge clk)
        if (mon_en) begin
            mon(0, ifa.mem_valid, ifa.rd_data);
            mon(1, ifb.mem_valid, ifb.rd_data);
        end
    task automatic drive(logic we, logic [3:0] be, logic [3:0] aw, logic [DW-1:0] wd, logic re, logic [3:0] ar);
        ifa.w_en = we; ifa.w_be = be; ifa.addr_w = aw; ifa.wr_data = wd; ifa.r_en = re; ifa.addr_r = ar;
        ifb.w_en = we; ifb.w_be = be; ifb.addr_w = aw; ifb.wr_data = wd; ifb.r_en = re; ifb.addr_r = ar;
    endtask
    task automatic step(logic we, logic [3:0] be, logic [3:0] aw, logic [DW-1:0] wd,
                        logic re, logic [3:0] ar, logic [DW-1:0] ea, logic [DW-1:0] eb);
        drive(we, be, aw, wd, re, ar);
        if (re && ifa.init_done) begin
            q[0].push_back(exp_t'{ea, cyc + 3});
            q[1].push_back(exp_t'{eb, cyc + 1});
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
    endtask
    task automatic wr(logic [3:0] aw, logic [DW-1:0] wd, logic [3:0] be);
        step(1, be, aw, wd, 0, 0, 0, 0);
    endtask
    task automatic rd(logic [3:0] ar, logic [DW-1:0] e);
        step(0, 0, 0, 0, 1, ar, e, e);
    endtask
    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // Releases reset with junk traffic on the bus that the sweep must ignore.
    task automatic release_and_wait();
        int rel;
        int n = 0;
        drive(1, 4'hF, 0, 32'hDEADBEEF, 1, 0);
        rel = cyc;
        rst_n = 1;
        while (!ifa.init_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("init_latency", cyc - rel, N);
        chk("init_done_b", {31'b0, ifb.init_done}, 1);
        @(posedge clk);
        #1;
    endtask
    initial begin
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1;
        chk("reset_valid_a", {31'b0, ifa.mem_valid}, 0);
        chk("reset_valid_b", {31'b0, ifb.mem_valid}, 0);
        chk("reset_init_done", {31'b0, ifa.init_done}, 0);
        release_and_wait();
        for (int i = 0; i < N; i++) rd(4'(i), 0);
        wr(5, 32'hAAAAAAAA, 4'hF);
        wr(5, 32'h55555555, 4'h1);
        rd(5, 32'hAAAAAA55);
        wr(5, 32'hFFFFFFFF, 4'h0);
        rd(5, 32'hAAAAAA55);
        for (int i = 1; i <= 4; i++) wr(4'(i), 32'h01010101 * i, 4'hF);
        for (int i = 1; i <= 4; i++) rd(4'(i), 32'h01010101 * i);
        wr(7, 32'h11111111, 4'hF);
        step(1, 4'hF, 7, 32'h22222222, 1, 7, 32'h22222222, 32'h11111111);
        rd(7, 32'h22222222);
        step(1, 4'h2, 9, 32'hCCCCCCCC, 1, 9, 32'h0000CC00, 32'h00000000);
        rd(9, 32'h0000CC00);
        step(1, 4'hF, 4, 32'h99999999, 1, 3, 32'h03030303, 32'h03030303);
        rd(4, 32'h99999999);
        rd(2, 32'h02020202);
        wr(2, 32'h77777777, 4'hF);
        rd(2, 32'h77777777);
        idle(6);
        chk("drain_a", q[0].size(), 0);
        chk("drain_b", q[1].size(), 0);
        rd(1, 32'h01010101);
        rd(2, 32'h77777777);
        rst_n = 0;
        #1;
        chk("rst_valid_a", {31'b0, ifa.mem_valid}, 0);
        chk("rst_valid_b", {31'b0, ifb.mem_valid}, 0);
        chk("rst_data_b", ifb.rd_data, 0);
        chk("rst_init_done", {31'b0, ifa.init_done}, 0);
        q[0].delete();
        q[1].delete();
        idle(2);
        rst_n = 1;
        idle(5);
        rst_n = 0;
        #1;
        chk("midsweep_init_done", {31'b0, ifa.init_done}, 0);
        idle(1);
        release_and_wait();
        rd(0, 0);
        rd(5, 0);
        rd(15, 0);
        idle(6);
        chk("final_drain_a", q[0].size(), 0);
        chk("final_drain_b", q[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
